// File: rtl/tt_rr_grant_sched.sv
// ---------------------------------------------------------------------------
// tt_rr_grant_sched
//   Four-requester round-robin grant scheduler sharing one datapath slot.
//   Requests are registered, one owner is picked, the grant is held for the
//   owner's burst, and a one-cycle turnaround separates grants.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : slot timer revokes a grant after SLOT_CYCLES cycles and
//                 pulses timeout on that GRANT->GAP edge.
//     undefined : no timer; timeout is tied to 0.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   ena        clock enable; when 0 all state and outputs hold
//   req[3:0]   level request per requester
//   done[3:0]  end-of-burst pulse, honoured only from the current owner
//   gnt[3:0]   one-hot grant (registered)
//   gnt_valid  OR of gnt (registered)
//   gnt_id     current/last owner index, round-robin pointer (registered)
//   busy       1 in GRANT or GAP (registered)
//   timeout    1-cycle pulse when the slot timer revokes a grant (registered)
// ---------------------------------------------------------------------------
module tt_rr_grant_sched #(
    parameter int unsigned NREQ        = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned SLOT_CYCLES = 8,
    parameter int unsigned TIMER_W     = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ena,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] gnt,
    output logic            gnt_valid,
    output logic [1:0]      gnt_id,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [NREQ-1:0] req_q;

    logic [NREQ-1:0] gnt_nxt;
    logic [1:0]      gnt_id_nxt;
    logic            timeout_nxt;

    logic [1:0]      pick_id;
    logic            pick_any;
    logic            owner_drop;
    logic            owner_done;
    logic            expire;
    logic            grant_end;

`ifdef ARB_TIMEOUT_EN
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] timer_nxt;

    assign expire = (timer == TIMER_W'(SLOT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    assign owner_drop = ~req_q[gnt_id];
    assign owner_done = done[gnt_id];
    assign grant_end  = owner_drop | owner_done | expire;

    // Round-robin pick: search gnt_id+1 .. gnt_id+4 (mod 4). Walking the
    // offsets from far to near lets the nearest set requester win last.
    always_comb begin
        logic [1:0] idx;
        pick_id  = gnt_id;
        pick_any = 1'b0;
        idx      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            idx = 2'(gnt_id + 2'(k));
            if (req_q[idx]) begin
                pick_id  = idx;
                pick_any = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_any)  state_nxt = S_GRANT;
            S_GRANT: if (grant_end) state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values; registered below
    always_comb begin
        gnt_nxt     = gnt;
        gnt_id_nxt  = gnt_id;
        timeout_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        timer_nxt   = timer;
`endif
        case (state)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_nxt    = NREQ'(1) << pick_id;
                    gnt_id_nxt = pick_id;
`ifdef ARB_TIMEOUT_EN
                    timer_nxt  = '0;
`endif
                end
            end
            S_GRANT: begin
                if (grant_end) begin
                    gnt_nxt     = '0;
                    // Only a pure timer revocation is reported; done wins ties.
                    timeout_nxt = expire & ~owner_done & ~owner_drop;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    timer_nxt = timer + TIMER_W'(1);
`endif
                end
            end
            default: begin
                gnt_nxt = '0;
            end
        endcase
    end

    // Registered outputs and request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q     <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= 2'd3;
            busy      <= 1'b0;
            timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timer     <= '0;
`endif
        end else if (ena) begin
            req_q     <= req;
            gnt       <= gnt_nxt;
            gnt_valid <= |gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            busy      <= (state_nxt != S_IDLE);
            timeout   <= timeout_nxt;
`ifdef ARB_TIMEOUT_EN
            timer     <= timer_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_tt_rr_grant_sched.sv
// ---------------------------------------------------------------------------
// tb_tt_rr_grant_sched
//   Self-checking bench for tt_rr_grant_sched: directed scenarios followed by
//   randomized req/done/ena/rst traffic, compared every cycle against a
//   behavioural model (owner / gap / pointer bookkeeping).
//   Honours ARB_TIMEOUT_EN the same way as the design (SLOT_CYCLES = 8).
// ---------------------------------------------------------------------------
module tb_tt_rr_grant_sched;

    localparam int unsigned SLOT = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [3:0] m_req_q = '0;
    int         m_owner = -1;   // -1: nobody holds the slot
    int         m_ptr   = 3;    // last owner, round-robin pointer
    bit         m_gap   = 1'b0; // turnaround cycle pending
    int         m_len   = 0;    // cycles the current owner has held the slot
    bit         m_tmo   = 1'b0;

    tt_rr_grant_sched dut (
        .clk       (clk),
        .rst       (rst),
        .ena       (ena),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        if (rst) begin
            m_req_q = '0;
            m_owner = -1;
            m_ptr   = 3;
            m_gap   = 1'b0;
            m_len   = 0;
            m_tmo   = 1'b0;
        end else if (ena) begin
            m_tmo = 1'b0;
            if (m_owner >= 0) begin
                bit dropped, finished, expired;
                dropped  = !m_req_q[m_owner];
                finished = done[m_owner];
                expired  = TMO_EN && (m_len == SLOT);
                if (dropped || finished || expired) begin
                    m_tmo   = expired && !finished && !dropped;
                    m_owner = -1;
                    m_gap   = 1'b1;
                end else begin
                    m_len++;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_owner < 0 && m_req_q[(m_ptr + k) % 4]) begin
                        m_owner = (m_ptr + k) % 4;
                    end
                end
                if (m_owner >= 0) begin
                    m_ptr = m_owner;
                    m_len = 1;
                end
            end
            m_req_q = req;
        end
    endtask

    task automatic compare_all();
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        check_val("gnt", 32'(gnt), 32'(exp_gnt));
        check_val("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check_val("gnt_id", 32'(gnt_id), 32'(m_ptr));
        check_val("busy", 32'(busy), 32'((m_owner >= 0) || m_gap));
        check_val("timeout", 32'(timeout), 32'(m_tmo));
        check_val("onehot", 32'($countones(gnt) <= 1), 32'(1));
    endtask

    // Drive inputs on the falling edge, clock, then check just after the edge.
    task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic [3:0] dn);
        @(negedge clk);
        rst  = r;
        ena  = e;
        req  = rq;
        done = dn;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; req = '0; done = '0;

        // Reset state
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        check_val("rst_gnt_id", 32'(gnt_id), 32'd3);
        check_val("rst_gnt", 32'(gnt), 32'd0);

        // All requesting: requester 0 wins two edges later and keeps the slot
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_val("lat1_gnt", 32'(gnt), 32'd0);
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_val("lat2_gnt", 32'(gnt), 32'b0001);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_val("hold_gnt", 32'(gnt), 32'b0001);

        // Done from owner rotates through 1,2,3,0
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'b1111, gnt);

        // Owner 2 ignores done from non-owners, then ends on its own done
        step(1'b1, 1'b1, 4'b0000, 4'b0000);
        step(1'b0, 1'b1, 4'b0100, 4'b0000);
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_val("own2_gnt", 32'(gnt), 32'b0100);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 4'b1111, 4'b1011);
        check_val("nonowner_done", 32'(gnt), 32'b0100);
        step(1'b0, 1'b1, 4'b1111, 4'b0100);
        check_val("owner_done", 32'(gnt), 32'b0000);

        // Reset mid-grant drops the grant on that edge
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        step(1'b1, 1'b1, 4'b1111, 4'b0000);
        check_val("midrst_gnt", 32'(gnt), 32'd0);
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        step(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_val("postrst_gnt", 32'(gnt), 32'b0001);

        // Long held grants with enable gaps exercise expiry and freeze
        for (int i = 0; i < 40; i++)
            step(1'b0, (i % 7) != 3, 4'b0101, 4'b0000);

        // Randomized traffic
        begin
            logic [3:0] rq;
            rq = 4'($urandom);
            for (int i = 0; i < 4000; i++) begin
                logic r, e;
                logic [3:0] dn;
                if ($urandom_range(15) == 0) rq = 4'($urandom);
                dn = ($urandom_range(7) == 0) ? 4'($urandom) : 4'b0000;
                e  = ($urandom_range(9) != 0);
                r  = ($urandom_range(199) == 0);
                step(r, e, rq, dn);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
